// File: rtl/io_hub_pkg.sv
// Shared register map and STATUS layout for io_peripheral_hub.
package io_hub_pkg;

    localparam int unsigned REG_SEL_W = 3;

    localparam logic [REG_SEL_W-1:0] OFF_LED    = 3'd0;
    localparam logic [REG_SEL_W-1:0] OFF_SW     = 3'd1;
    localparam logic [REG_SEL_W-1:0] OFF_TIMER  = 3'd2;
    localparam logic [REG_SEL_W-1:0] OFF_CMP    = 3'd3;
    localparam logic [REG_SEL_W-1:0] OFF_STATUS = 3'd4;
    localparam logic [REG_SEL_W-1:0] OFF_TXDATA = 3'd5;

    localparam int unsigned ST_MATCH     = 0;
    localparam int unsigned ST_OVERFLOW  = 1;
    localparam int unsigned ST_EMPTY     = 2;
    localparam int unsigned ST_FULL      = 3;
    localparam int unsigned ST_COUNT_LSB = 8;
    localparam int unsigned ST_COUNT_W   = 8;

endpackage

// File: rtl/io_peripheral_hub_sync_fifo.sv
// Single-clock FIFO; pointers carry an extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;

    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign do_push = push & (~full | do_pop);

    // Gate the head to zero when empty so a flushed FIFO presents clean data.
    assign dout = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/io_peripheral_hub.sv
// Memory-mapped CPU peripheral block: LEDs, synchronized switches, 64-bit timer with compare,
// and a TX FIFO drained by a valid/ready consumer.
module io_peripheral_hub
    import io_hub_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_0000_1000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SW_W       = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [63:0]     address,
    input  logic [63:0]     Databus,
    input  logic            Write,
    input  logic [SW_W-1:0] sw_in,
    output logic [63:0]     data_out,
    output logic [63:0]     led_out,
    output logic            tx_valid,
    output logic [63:0]     tx_data,
    input  logic            tx_ready,
    output logic            timer_irq
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                 hit;
    logic [REG_SEL_W-1:0] sel;
    logic                 wr_led, wr_timer, wr_cmp, wr_status, wr_tx;
    logic                 unused_addr;

    logic [63:0]     led_q, led_d;
    logic [63:0]     timer_q, timer_d;
    logic [63:0]     cmp_q, cmp_d;
    logic            match_q, match_d;
    logic            ovf_q, ovf_d;
    logic [SW_W-1:0] sw_meta_q, sw_sync_q;

    logic             fifo_pop, fifo_empty, fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic [63:0]      status;

    assign hit         = (address[63:6] == BASE_ADDR[63:6]);
    assign sel         = address[5:3];
    assign unused_addr = ^address[2:0];

    assign wr_led    = Write & hit & (sel == OFF_LED);
    assign wr_timer  = Write & hit & (sel == OFF_TIMER);
    assign wr_cmp    = Write & hit & (sel == OFF_CMP);
    assign wr_status = Write & hit & (sel == OFF_STATUS);
    assign wr_tx     = Write & hit & (sel == OFF_TXDATA);

    assign fifo_pop  = tx_valid & tx_ready;
    assign tx_valid  = ~fifo_empty;
    assign led_out   = led_q;
    assign timer_irq = match_q;

    sync_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (wr_tx),
        .pop   (fifo_pop),
        .din   (Databus),
        .dout  (tx_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Sticky flags: a new set event in the same cycle as a W1C keeps the flag set.
    always_comb begin
        led_d   = wr_led ? Databus : led_q;
        cmp_d   = wr_cmp ? Databus : cmp_q;
        timer_d = wr_timer ? Databus : timer_q + 64'd1;
        match_d = (timer_q == cmp_q) | (match_q & ~(wr_status & Databus[ST_MATCH]));
        ovf_d   = (wr_tx & fifo_full & ~fifo_pop)
                | (ovf_q & ~(wr_status & Databus[ST_OVERFLOW]));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            led_q     <= '0;
            timer_q   <= '0;
            cmp_q     <= '1;
            match_q   <= 1'b0;
            ovf_q     <= 1'b0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            led_q     <= led_d;
            timer_q   <= timer_d;
            cmp_q     <= cmp_d;
            match_q   <= match_d;
            ovf_q     <= ovf_d;
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
        end
    end

    always_comb begin
        status                                = '0;
        status[ST_MATCH]                      = match_q;
        status[ST_OVERFLOW]                   = ovf_q;
        status[ST_EMPTY]                      = fifo_empty;
        status[ST_FULL]                       = fifo_full;
        status[ST_COUNT_LSB +: ST_COUNT_W]    = ST_COUNT_W'(fifo_count);
    end

    always_comb begin
        data_out = '0;
        if (hit) begin
            case (sel)
                OFF_LED:    data_out = led_q;
                OFF_SW:     data_out = 64'(sw_sync_q);
                OFF_TIMER:  data_out = timer_q;
                OFF_CMP:    data_out = cmp_q;
                OFF_STATUS: data_out = status;
                default:    data_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_peripheral_hub.sv
// Directed, table-driven bench for io_peripheral_hub.
module tb_io_peripheral_hub;

    localparam logic [63:0] BASE = 64'h0000_0000_0000_1000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] address;
    logic [63:0] Databus;
    logic        Write;
    logic [7:0]  sw_in;
    logic [63:0] data_out;
    logic [63:0] led_out;
    logic        tx_valid;
    logic [63:0] tx_data;
    logic        tx_ready;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rd;
        logic [63:0] exp_led;
    } vec_t;

    vec_t        vecs[15];
    logic [63:0] exp_q[4];

    io_peripheral_hub #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (4),
        .SW_W       (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .address   (address),
        .Databus   (Databus),
        .Write     (Write),
        .sw_in     (sw_in),
        .data_out  (data_out),
        .led_out   (led_out),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .timer_irq (timer_irq)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] off, input logic [63:0] d);
        address = BASE + {58'd0, off, 3'b000};
        Databus = d;
        Write   = 1'b1;
        cyc();
        Write   = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [2:0] off, input logic [63:0] exp);
        address = BASE + {58'd0, off, 3'b000};
        Write   = 1'b0;
        #1;
        check(nm, data_out, exp);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 64'h1000, 64'h0,    64'h0,    64'h0};
        vecs[1]  = '{1'b1, 64'h1000, 64'hA5,   64'h0,    64'hA5};
        vecs[2]  = '{1'b0, 64'h1005, 64'h0,    64'hA5,   64'hA5};
        vecs[3]  = '{1'b1, 64'h1040, 64'h77,   64'h0,    64'hA5};
        vecs[4]  = '{1'b1, 64'h0FF8, 64'h66,   64'h0,    64'hA5};
        vecs[5]  = '{1'b0, 64'h1018, 64'h0,    ONES,     64'hA5};
        vecs[6]  = '{1'b1, 64'h1018, 64'h1234, ONES,     64'hA5};
        vecs[7]  = '{1'b0, 64'h101F, 64'h0,    64'h1234, 64'hA5};
        vecs[8]  = '{1'b1, 64'h1030, 64'hDEAD, 64'h0,    64'hA5};
        vecs[9]  = '{1'b0, 64'h1038, 64'h0,    64'h0,    64'hA5};
        vecs[10] = '{1'b0, 64'h1030, 64'h0,    64'h0,    64'hA5};
        vecs[11] = '{1'b0, 64'h1020, 64'h0,    64'h4,    64'hA5};
        vecs[12] = '{1'b0, 64'h1028, 64'h0,    64'h0,    64'hA5};
        vecs[13] = '{1'b1, 64'h1000, 64'h0123_4567_89AB_CDEF, 64'hA5, 64'h0123_4567_89AB_CDEF};
        vecs[14] = '{1'b1, 64'h1008, 64'hFF,   64'h0,    64'h0123_4567_89AB_CDEF};

        reset = 1'b1; address = '0; Databus = '0; Write = 1'b0; sw_in = '0; tx_ready = 1'b0;
        repeat (2) cyc();
        reset = 1'b0;

        // Reset state
        check("rst_led", led_out, 64'h0);
        check("rst_tx_valid", {63'd0, tx_valid}, 64'h0);
        check("rst_tx_data", tx_data, 64'h0);
        check("rst_irq", {63'd0, timer_irq}, 64'h0);
        rd_chk("rst_timer", 3'd2, 64'h0);
        rd_chk("rst_status", 3'd4, 64'h4);

        // Register access table
        for (int i = 0; i < 15; i++) begin
            address = vecs[i].addr;
            Databus = vecs[i].wdata;
            Write   = vecs[i].wr;
            #1;
            check($sformatf("vec%0d_rd", i), data_out, vecs[i].exp_rd);
            cyc();
            Write = 1'b0;
            check($sformatf("vec%0d_led", i), led_out, vecs[i].exp_led);
        end

        // Timer wrap and compare match
        wr(3'd3, 64'h0);
        wr(3'd2, 64'hFFFF_FFFF_FFFF_FFFE);
        rd_chk("tmr_load", 3'd2, 64'hFFFF_FFFF_FFFF_FFFE);
        cyc();
        rd_chk("tmr_max", 3'd2, ONES);
        cyc();
        rd_chk("tmr_wrap", 3'd2, 64'h0);
        check("irq_before", {63'd0, timer_irq}, 64'h0);
        cyc();
        check("irq_after", {63'd0, timer_irq}, 64'h1);
        rd_chk("status_match", 3'd4, 64'h5);

        // W1C clears, but loses to a simultaneous new match
        wr(3'd3, 64'd200);
        wr(3'd2, 64'd199);
        check("irq_sticky", {63'd0, timer_irq}, 64'h1);
        wr(3'd4, 64'h1);
        check("irq_w1c", {63'd0, timer_irq}, 64'h0);
        wr(3'd4, 64'h1);
        check("irq_set_wins", {63'd0, timer_irq}, 64'h1);
        wr(3'd4, 64'h1);
        check("irq_clear2", {63'd0, timer_irq}, 64'h0);
        wr(3'd3, ONES);

        // FIFO fill, overflow, hold, drain
        address = BASE + 64'h28; Databus = 64'd1; Write = 1'b1;
        #1;
        check("no_bypass", {63'd0, tx_valid}, 64'h0);
        cyc();
        Write = 1'b0;
        check("push1_valid", {63'd0, tx_valid}, 64'h1);
        check("push1_data", tx_data, 64'd1);
        for (int k = 2; k <= 4; k++) wr(3'd5, 64'(k));
        rd_chk("full_status", 3'd4, 64'h408);
        wr(3'd5, 64'd5);
        rd_chk("ovf_status", 3'd4, 64'h40A);
        repeat (2) cyc();
        check("hold_data", tx_data, 64'd1);
        tx_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("drain%0d_valid", k), {63'd0, tx_valid}, 64'h1);
            check($sformatf("drain%0d_data", k), tx_data, 64'(k));
            cyc();
        end
        check("drained_valid", {63'd0, tx_valid}, 64'h0);
        tx_ready = 1'b0;
        wr(3'd4, 64'h2);
        rd_chk("ovf_w1c", 3'd4, 64'h4);

        // Push into full FIFO with a simultaneous pop
        for (int k = 10; k <= 13; k++) wr(3'd5, 64'(k));
        address = BASE + 64'h28; Databus = 64'd9; Write = 1'b1; tx_ready = 1'b1;
        cyc();
        Write = 1'b0; tx_ready = 1'b0;
        rd_chk("pushpop_status", 3'd4, 64'h408);
        check("pushpop_head", tx_data, 64'd11);
        exp_q[0] = 64'd11; exp_q[1] = 64'd12; exp_q[2] = 64'd13; exp_q[3] = 64'd9;
        tx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("pp_drain%0d", k), tx_data, exp_q[k]);
            cyc();
        end
        check("pp_empty", {63'd0, tx_valid}, 64'h0);
        tx_ready = 1'b0;

        // Switch synchronizer latency
        sw_in = 8'h3C;
        rd_chk("sw_gap0", 3'd1, 64'h0);
        cyc();
        rd_chk("sw_gap1", 3'd1, 64'h0);
        cyc();
        rd_chk("sw_sync", 3'd1, 64'h3C);

        // Reset mid-activity
        wr(3'd0, 64'hFF);
        wr(3'd5, 64'h21);
        wr(3'd5, 64'h22);
        check("pre_rst_valid", {63'd0, tx_valid}, 64'h1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("rst2_valid", {63'd0, tx_valid}, 64'h0);
        check("rst2_led", led_out, 64'h0);
        check("rst2_tx_data", tx_data, 64'h0);
        rd_chk("rst2_status", 3'd4, 64'h4);
        rd_chk("rst2_cmp", 3'd3, ONES);
        rd_chk("rst2_timer", 3'd2, 64'h0);
        rd_chk("rst2_sw", 3'd1, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
